// File: rtl/spi_master.sv
//------------------------------------------------------------------------------
// Module      : spi_master
// Description : Controller end of the single-byte SPI register protocol.
//               One transaction = header byte {RW, ADDR} MSB first, one
//               turnaround SCLK cycle, then one data byte. Writes shift
//               WDATA out on MOSI; reads capture MISO into RDATA.
//               SPI mode 0: SCLK idles low, peripheral samples MOSI on the
//               SCLK rise, controller samples MISO on the SCLK rise.
// Ports       : clk    - system clock, all logic on posedge
//               rst    - synchronous reset, active-high
//               start  - request; accepted when start=1 and busy=0
//               rw     - 0 = write, 1 = read (captured at accept)
//               addr   - register address (captured at accept)
//               wdata  - write data (captured at accept)
//               rdata  - read data, updated at DONE of a read only
//               busy   - high from the cycle after accept until DONE
//               done   - single-cycle completion pulse
//               cs     - chip select, active-low
//               sclk   - serial clock, idles low
//               mosi   - controller -> peripheral data
//               miso   - peripheral -> controller data
// Options     : SPI_MASTER_MISO_SYNC_EN - when defined, MISO passes through a
//               2-flop synchronizer and is sampled 2 CLKs after the SCLK
//               rise (requires CLK_DIV >= 3). External timing is unchanged.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_master #(
  parameter int CLK_DIV = 5,   // CLK cycles per SCLK half-period
  parameter int ADDR_W  = 7,   // address width, header = 1 + ADDR_W bits
  parameter int DATA_W  = 8    // data byte width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  //--------------------------------------------------------------------------
  // Derived constants
  //--------------------------------------------------------------------------
  localparam int c_hdr_w   = 1 + ADDR_W;
  localparam int c_cnt_w   = $clog2(2 * CLK_DIV);
  localparam int c_bit_max = (c_hdr_w > DATA_W) ? c_hdr_w : DATA_W;
  localparam int c_bit_w   = $clog2(c_bit_max);

  // Phase counter values inside one bit slot (slot = 2*CLK_DIV CLKs).
  // The counter reads 0 in the cycle after the slot's first edge, so the
  // edge taken while it reads CLK_DIV-1 is the one that raises SCLK and the
  // edge taken while it reads 2*CLK_DIV-1 closes the slot.
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_slot_last = c_cnt_w'(2 * CLK_DIV - 1);

`ifdef SPI_MASTER_MISO_SYNC_EN
  // Two synchronizer stages delay MISO by 2 CLKs, so the sample point moves
  // 2 CLKs past the SCLK-rise edge while staying inside the high half.
  localparam logic [c_cnt_w-1:0] c_samp_pt   = c_cnt_w'(CLK_DIV + 1);
`else
  localparam logic [c_cnt_w-1:0] c_samp_pt   = c_cnt_w'(CLK_DIV - 1);
`endif

  localparam logic [c_bit_w-1:0] c_hdr_last  = c_bit_w'(c_hdr_w - 1);
  localparam logic [c_bit_w-1:0] c_dat_last  = c_bit_w'(DATA_W - 1);

  //--------------------------------------------------------------------------
  // State encoding
  //--------------------------------------------------------------------------
  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_hdr  = 3'd1;
  localparam logic [2:0] c_st_gap  = 3'd2;
  localparam logic [2:0] c_st_data = 3'd3;
  localparam logic [2:0] c_st_hold = 3'd4;
  localparam logic [2:0] c_st_done = 3'd5;

  //--------------------------------------------------------------------------
  // Registers
  //--------------------------------------------------------------------------
  logic [2:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;      // CLK phase within the current slot
  logic [c_bit_w-1:0] r_bit;      // bit index within HDR or DATA
  logic               r_rw;       // captured direction
  logic [c_hdr_w-1:0] r_hdr_sr;   // header, MSB is the bit on the wire
  logic [DATA_W-1:0]  r_dat_sr;   // write data, MSB is the bit on the wire
  logic [DATA_W-1:0]  r_rx_sr;    // read data being assembled
  logic [DATA_W-1:0]  r_rdata;
  logic               r_busy;
  logic               r_done;
  logic               r_cs;
  logic               r_sclk;
  logic               r_mosi;

  //--------------------------------------------------------------------------
  // MISO source: direct pin or synchronized copy
  //--------------------------------------------------------------------------
  logic w_miso;

`ifdef SPI_MASTER_MISO_SYNC_EN
  logic r_miso_s1;
  logic r_miso_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= miso;
      r_miso_s2 <= r_miso_s1;
    end
  end

  assign w_miso = r_miso_s2;
`else
  assign w_miso = miso;
`endif

  //--------------------------------------------------------------------------
  // Slot timing decodes
  //--------------------------------------------------------------------------
  logic w_in_slot;
  logic w_rise;
  logic w_slot_end;
  logic w_sample;

  assign w_in_slot  = (r_state == c_st_hdr) || (r_state == c_st_gap) ||
                      (r_state == c_st_data);
  assign w_rise     = w_in_slot && (r_cnt == c_half_last);
  assign w_slot_end = w_in_slot && (r_cnt == c_slot_last);
  assign w_sample   = (r_state == c_st_data) && r_rw && (r_cnt == c_samp_pt);

  //--------------------------------------------------------------------------
  // Main FSM and datapath
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_st_idle;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_rw     <= 1'b0;
      r_hdr_sr <= '0;
      r_dat_sr <= '0;
      r_rx_sr  <= '0;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cs     <= 1'b1;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      case (r_state)
        //----------------------------------------------------------------
        // IDLE also covers the DONE pulse cycle, so a START seen there is
        // accepted and transfers run back to back.
        //----------------------------------------------------------------
        c_st_idle: begin
          if (start) begin
            r_state  <= c_st_hdr;
            r_cs     <= 1'b0;
            r_sclk   <= 1'b0;
            r_mosi   <= rw;
            r_busy   <= 1'b1;
            r_rw     <= rw;
            r_hdr_sr <= {rw, addr};
            r_dat_sr <= wdata;
            r_cnt    <= '0;
            r_bit    <= '0;
          end
        end

        //----------------------------------------------------------------
        // Serial slots: low half then high half, MOSI changes only at the
        // slot boundary so it is stable around the SCLK rise.
        //----------------------------------------------------------------
        c_st_hdr, c_st_gap, c_st_data: begin
          r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;

          if (w_rise) begin
            r_sclk <= 1'b1;
          end

          if (w_sample) begin
            r_rx_sr <= {r_rx_sr[DATA_W-2:0], w_miso};
          end

          if (w_slot_end) begin
            r_sclk <= 1'b0;

            if (r_state == c_st_hdr) begin
              // Rotate so the next header bit becomes the MSB.
              r_hdr_sr <= {r_hdr_sr[c_hdr_w-2:0], r_hdr_sr[c_hdr_w-1]};
              if (r_bit == c_hdr_last) begin
                r_state <= c_st_gap;
                r_bit   <= '0;
                r_mosi  <= 1'b0;
              end else begin
                r_bit  <= r_bit + 1'b1;
                r_mosi <= r_hdr_sr[c_hdr_w-2];
              end
            end else if (r_state == c_st_gap) begin
              r_state <= c_st_data;
              r_bit   <= '0;
              r_mosi  <= r_rw ? 1'b0 : r_dat_sr[DATA_W-1];
            end else begin
              r_dat_sr <= {r_dat_sr[DATA_W-2:0], r_dat_sr[DATA_W-1]};
              if (r_bit == c_dat_last) begin
                // Last slot's high half is over: release the bus.
                r_state <= c_st_hold;
                r_cs    <= 1'b1;
                r_mosi  <= 1'b0;
                r_bit   <= '0;
              end else begin
                r_bit  <= r_bit + 1'b1;
                r_mosi <= r_rw ? 1'b0 : r_dat_sr[DATA_W-2];
              end
            end
          end
        end

        //----------------------------------------------------------------
        // Minimum deselect time: one full slot with CS high.
        //----------------------------------------------------------------
        c_st_hold: begin
          if (r_cnt == c_slot_last) begin
            r_state <= c_st_done;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        //----------------------------------------------------------------
        // Completion: DONE and the BUSY drop land on the same edge, so the
        // two are never high together.
        //----------------------------------------------------------------
        c_st_done: begin
          r_state <= c_st_idle;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (r_rw) begin
            r_rdata <= r_rx_sr;
          end
        end

        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign rdata = r_rdata;
  assign busy  = r_busy;
  assign done  = r_done;
  assign cs    = r_cs;
  assign sclk  = r_sclk;
  assign mosi  = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
//------------------------------------------------------------------------------
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master. A table of transactions
//               is driven, expected results are queued at accept and popped
//               at DONE; extra sequences cover ignored START, reset abort
//               and back-to-back transfers.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_spi_master;

  localparam int CLK_DIV  = 5;
  localparam int c_cs_low = 34 * CLK_DIV;
  localparam int c_lat    = 36 * CLK_DIV + 1;
  localparam int c_limit  = 40 * CLK_DIV + 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       cs;
  logic       sclk;
  logic       mosi;
  logic       miso = 1'b0;

  spi_master #(.CLK_DIV(CLK_DIV), .ADDR_W(7), .DATA_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .rw    (rw),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .busy  (busy),
    .done  (done),
    .cs    (cs),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  miso_byte;
    logic [16:0] exp_mosi;    // MOSI at the 17 SCLK rises, first bit in MSB
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[7];
  vec_t sb_q[$];
  vec_t e;
  vec_t v_abort;
  vec_t v_after;
  vec_t v_b2b;

  int n_cmp = 0;
  int n_err = 0;

  // Monitor state
  int          cyc = 0;
  int          acc_edge = 0;
  int          rises = 0;
  int          cs_low = 0;
  int          gap_cnt = 0;
  int          last_gap = 0;
  int          windows = 0;
  int          done_cnt = 0;
  logic [16:0] bits = '0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [7:0]  cur_miso = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Bus monitor, peripheral MISO model and scoreboard checker.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
    end else begin
      if (done === 1'b1) begin
        done_cnt++;
        check("busy_with_done", {31'd0, busy}, 32'd0);
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got DONE, expected none queued");
        end else begin
          e = sb_q.pop_front();
          check("mosi_bits", {15'd0, bits}, {15'd0, e.exp_mosi});
          check("sclk_rises", rises, 17);
          check("cs_low_clks", cs_low, c_cs_low);
          check("accept_to_done", cyc - acc_edge, c_lat);
          check("rdata", {24'd0, rdata}, {24'd0, e.exp_rdata});
        end
      end
      if (start === 1'b1 && busy === 1'b0) acc_edge = cyc + 1;
      if (cs === 1'b0 && prev_cs === 1'b1) begin
        windows++;
        last_gap = gap_cnt;
        gap_cnt  = 0;
        cs_low   = 0;
        rises    = 0;
        bits     = '0;
        miso     = 1'b0;
      end
      if (cs === 1'b0) cs_low++;
      else gap_cnt++;
      if (sclk === 1'b1 && prev_sclk === 1'b0) begin
        rises++;
        bits = {bits[15:0], mosi};
      end
      // Peripheral shifts its byte out on SCLK falls during the data phase.
      if (sclk === 1'b0 && prev_sclk === 1'b1 && rises >= 9 && rises <= 16)
        miso = cur_miso[16 - rises];
      prev_cs   = cs;
      prev_sclk = sclk;
    end
  end

  task automatic send(input vec_t v, input bit push);
    int k;
    @(posedge clk);
    #1;
    rw       = v.rw;
    addr     = v.addr;
    wdata    = v.wdata;
    cur_miso = v.miso_byte;
    start    = 1'b1;
    for (k = 0; k < c_limit; k++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    if (k == c_limit) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got busy=%0b, expected 0", busy);
    end
    if (push) sb_q.push_back(v);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    for (k = 0; k < c_limit; k++) begin
      @(posedge clk);
      if (done_cnt >= target) break;
    end
    if (k == c_limit) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got %0d dones, expected %0d", done_cnt, target);
    end
  endtask

  initial begin
    int w0;
    int d0;
    int k;

    rst   = 1'b1;
    start = 1'b0;
    rw    = 1'b0;
    addr  = '0;
    wdata = '0;

    //          rw    addr   wdata  miso   exp_mosi                     exp_rdata
    vecs[0] = '{1'b0, 7'h55, 8'h33, 8'h00, 17'b01010101_0_00110011, 8'h00};
    vecs[1] = '{1'b1, 7'h55, 8'h00, 8'h33, 17'b11010101_0_00000000, 8'h33};
    vecs[2] = '{1'b0, 7'h7F, 8'hFF, 8'h00, 17'b01111111_0_11111111, 8'h33};
    vecs[3] = '{1'b1, 7'h00, 8'hFF, 8'hA5, 17'b10000000_0_00000000, 8'hA5};
    vecs[4] = '{1'b0, 7'h00, 8'h80, 8'hFF, 17'b00000000_0_10000000, 8'hA5};
    vecs[5] = '{1'b1, 7'h2A, 8'h00, 8'h5A, 17'b10101010_0_00000000, 8'h5A};
    vecs[6] = '{1'b0, 7'h01, 8'h01, 8'h00, 17'b00000001_0_00000001, 8'h5A};
    v_abort = '{1'b1, 7'h2A, 8'h00, 8'hFF, 17'b10101010_0_00000000, 8'hFF};
    v_after = '{1'b1, 7'h12, 8'h00, 8'hC3, 17'b10010010_0_00000000, 8'hC3};
    v_b2b   = '{1'b0, 7'h0F, 8'h3C, 8'h00, 17'b00001111_0_00111100, 8'hC3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs",    {31'd0, cs},    32'd1);
    check("rst_sclk",  {31'd0, sclk},  32'd0);
    check("rst_mosi",  {31'd0, mosi},  32'd0);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Table-driven transactions
    for (int i = 0; i < 7; i++) begin
      w0 = windows;
      d0 = done_cnt;
      send(vecs[i], 1'b1);
      if (i == 0) begin
        // START pulsed mid-write must be ignored, not queued.
        repeat (40) @(posedge clk);
        #1;
        start = 1'b1;
        rw    = 1'b1;
        addr  = 7'h00;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      wait_done(d0 + 1);
      repeat (30) @(posedge clk);
      check("one_window", windows - w0, 1);
      check("one_done", done_cnt - d0, 1);
      check("rdata_held", {24'd0, rdata}, {24'd0, vecs[i].exp_rdata});
    end

    // Reset in the data phase of a read aborts with no DONE.
    send(v_abort, 1'b0);
    for (k = 0; k < c_limit; k++) begin
      @(negedge clk);
      if (rises >= 12) break;
    end
    check("abort_reached_data", {31'd0, (rises >= 12)}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_cs",    {31'd0, cs},    32'd1);
    check("abort_sclk",  {31'd0, sclk},  32'd0);
    check("abort_mosi",  {31'd0, mosi},  32'd0);
    check("abort_busy",  {31'd0, busy},  32'd0);
    check("abort_rdata", {24'd0, rdata}, 32'd0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (250) @(posedge clk);
    check("abort_no_done", done_cnt - d0, 0);

    d0 = done_cnt;
    send(v_after, 1'b1);
    wait_done(d0 + 1);
    repeat (10) @(posedge clk);
    check("after_abort_rdata", {24'd0, rdata}, 32'h0000_00C3);

    // Back-to-back: START held through DONE.
    d0 = done_cnt;
    w0 = windows;
    @(posedge clk);
    #1;
    rw       = v_b2b.rw;
    addr     = v_b2b.addr;
    wdata    = v_b2b.wdata;
    cur_miso = v_b2b.miso_byte;
    start    = 1'b1;
    for (k = 0; k < c_limit; k++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    sb_q.push_back(v_b2b);
    for (k = 0; k < c_limit; k++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    check("b2b_first_done", {31'd0, done}, 32'd1);
    sb_q.push_back(v_b2b);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_restart_busy", {31'd0, busy}, 32'd1);
    check("b2b_restart_cs",   {31'd0, cs},   32'd0);
    wait_done(d0 + 2);
    repeat (10) @(posedge clk);
    check("b2b_windows", windows - w0, 2);
    check("b2b_gap_ge_10", {31'd0, (last_gap >= 10)}, 32'd1);
    check("b2b_queue_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
